// File: rtl/otter_intr_pkg.sv
// Shared types and constants for the OTTER interrupt controller.
package otter_intr_pkg;

    localparam int MAX_SRC = 16;

    localparam logic [3:0] PEND_OFS = 4'h0;
    localparam logic [3:0] EN_OFS   = 4'h4;
    localparam logic [3:0] STAT_OFS = 4'h8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    // Lowest set index wins, so source 0 has the highest priority.
    function automatic logic [3:0] lowest_set(input logic [MAX_SRC-1:0] v);
        lowest_set = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction

endpackage

// File: rtl/otter_intr_ctrl_if.sv
// Bus and CPU-interrupt signals between the OTTER MCU (master) and the controller (slave).
interface otter_intr_ctrl_if;
    // iobus_wr is a single-cycle store strobe with no stall; cpu_intr is held
    // until a one-cycle cpu_ack pulse accepts it, or software withdraws it.
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic [31:0] ic_rdata;
    logic        cpu_intr;
    logic        cpu_ack;
    logic [3:0]  active_id;

    modport master (
        output iobus_addr, iobus_out, iobus_wr, cpu_ack,
        input  ic_rdata, cpu_intr, active_id
    );

    modport slave (
        input  iobus_addr, iobus_out, iobus_wr, cpu_ack,
        output ic_rdata, cpu_intr, active_id
    );
endinterface

// File: rtl/intr_sync_edge.sv
// One interrupt line: two-flop synchroniser followed by a rising-edge pulse.
module intr_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
endmodule

// File: rtl/otter_intr_ctrl.sv
// Interrupt controller: pending/enable registers, fixed priority, request/ack/EOI FSM.
module otter_intr_ctrl
    import otter_intr_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    otter_intr_ctrl_if.slave   bus,
    output state_t             state_dbg
);
    localparam logic [MAX_SRC-1:0] SRC_MASK = MAX_SRC'((64'd1 << NUM_SRC) - 64'd1);

    state_t               state;
    logic                 in_service;
    logic [MAX_SRC-1:0]   pend, en;
    logic [NUM_SRC-1:0]   rise_v;
    logic [MAX_SRC-1:0]   rise16;
    logic [MAX_SRC-1:0]   wdata, eligible, clr;
    logic [3:0]           winner, ofs;
    logic                 hit, pend_wr, en_wr, eoi, ack_req, drop;
    logic                 unused_wdata_hi;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        intr_sync_edge u_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (irq_src[g]),
            .rise (rise_v[g])
        );
    end

    always_comb begin
        rise16 = '0;
        rise16[NUM_SRC-1:0] = rise_v;
    end

    assign hit             = (bus.iobus_addr[31:4] == BASE_ADDR[31:4]);
    assign ofs             = bus.iobus_addr[3:0];
    assign wdata           = bus.iobus_out[MAX_SRC-1:0] & SRC_MASK;
    assign unused_wdata_hi = ^bus.iobus_out[31:MAX_SRC];
    assign pend_wr         = bus.iobus_wr && hit && (ofs == PEND_OFS);
    assign en_wr           = bus.iobus_wr && hit && (ofs == EN_OFS);
    assign eoi             = bus.iobus_wr && hit && (ofs == STAT_OFS);

    assign eligible = pend & en;
    assign winner   = lowest_set(eligible);
    assign ack_req  = (state == REQ) && bus.cpu_ack;
    // Software withdrawing the requested source cancels the request.
    assign drop     = (en_wr && !wdata[bus.active_id]) || (pend_wr && wdata[bus.active_id]);
    assign clr      = (pend_wr ? wdata : '0) | (ack_req ? (MAX_SRC'(1) << bus.active_id) : '0);

    // A new edge beats any same-cycle clear of that bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            en   <= '0;
        end else begin
            pend <= ((pend & ~clr) | rise16) & SRC_MASK;
            if (en_wr) en <= wdata;
        end
    end

    // cpu_intr lags the REQ state by one edge; ack or drop pulls it low at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.cpu_intr  <= 1'b0;
            bus.active_id <= '0;
            in_service    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.cpu_intr <= 1'b0;
                    in_service   <= 1'b0;
                    if (|eligible) begin
                        bus.active_id <= winner;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (bus.cpu_ack) begin
                        state        <= SVC;
                        bus.cpu_intr <= 1'b0;
                        in_service   <= 1'b1;
                    end else if (drop) begin
                        state        <= IDLE;
                        bus.cpu_intr <= 1'b0;
                    end else begin
                        bus.cpu_intr <= 1'b1;
                    end
                end
                SVC: begin
                    bus.cpu_intr <= 1'b0;
                    if (eoi) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.cpu_intr <= 1'b0;
                    in_service   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.ic_rdata = '0;
        if (hit) begin
            case (ofs)
                PEND_OFS: bus.ic_rdata = {16'b0, pend};
                EN_OFS:   bus.ic_rdata = {16'b0, en};
                STAT_OFS: bus.ic_rdata = {27'b0, in_service, bus.active_id};
                default:  bus.ic_rdata = '0;
            endcase
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl: register map, priority, ack/EOI, withdraw, reset.
module tb_otter_intr_ctrl;
    import otter_intr_pkg::*;

    localparam logic [31:0] BASE = 32'h1100_0200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_src = '0;
    state_t     state_dbg;
    int         n_total = 0;
    int         n_bad = 0;

    otter_intr_ctrl_if bus ();

    otter_intr_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.iobus_addr = addr;
        bus.iobus_out  = data;
        bus.iobus_wr   = 1'b1;
        tick(1);
        bus.iobus_wr   = 1'b0;
        bus.iobus_addr = 32'h0;
    endtask

    task automatic chk_addr(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.iobus_addr = addr;
        #1;
        chk(tag, bus.ic_rdata, exp);
        bus.iobus_addr = 32'h0;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] ofs, input logic [31:0] exp);
        chk_addr(tag, BASE + {28'h0, ofs}, exp);
    endtask

    task automatic pulse_ack();
        bus.cpu_ack = 1'b1;
        tick(1);
        bus.cpu_ack = 1'b0;
    endtask

    task automatic wait_intr(input string tag, input int budget);
        int n = 0;
        while (!bus.cpu_intr && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(bus.cpu_intr), 32'd1);
    endtask

    initial begin
        bus.iobus_addr = 32'h0;
        bus.iobus_out  = 32'h0;
        bus.iobus_wr   = 1'b0;
        bus.cpu_ack    = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);

        // reset state
        chk_reg("rst_pend", PEND_OFS, 32'h0);
        chk_reg("rst_en", EN_OFS, 32'h0);
        chk_reg("rst_stat", STAT_OFS, 32'h0);
        chk("rst_intr", 32'(bus.cpu_intr), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));

        // single source, exact latency
        bus_write(BASE + 32'h4, 32'h05);
        irq_src[2] = 1'b1;
        tick(2);
        chk_reg("pend_early", PEND_OFS, 32'h0);
        tick(1);
        irq_src[2] = 1'b0;
        chk_reg("pend_set", PEND_OFS, 32'h04);
        chk("intr_not_yet", 32'(bus.cpu_intr), 32'd0);
        tick(1);
        chk("state_req", 32'(state_dbg), 32'(REQ));
        chk("intr_lag", 32'(bus.cpu_intr), 32'd0);
        tick(1);
        chk("intr_on", 32'(bus.cpu_intr), 32'd1);
        chk("id_2", 32'(bus.active_id), 32'd2);
        pulse_ack();
        chk("intr_off_ack", 32'(bus.cpu_intr), 32'd0);
        chk_reg("pend_cleared", PEND_OFS, 32'h0);
        chk_reg("stat_svc", STAT_OFS, 32'h12);
        pulse_ack();
        chk("ack_in_svc_ignored", 32'(state_dbg), 32'(SVC));
        bus_write(BASE + 32'h8, 32'h0);
        chk_reg("stat_eoi", STAT_OFS, 32'h02);
        chk("state_idle_eoi", 32'(state_dbg), 32'(IDLE));

        // two simultaneous sources: lower index first
        bus_write(BASE + 32'h4, 32'hFF);
        irq_src[5] = 1'b1;
        irq_src[1] = 1'b1;
        tick(3);
        irq_src = '0;
        wait_intr("intr_pair", 10);
        chk("id_1_first", 32'(bus.active_id), 32'd1);
        chk_reg("pend_pair", PEND_OFS, 32'h22);
        pulse_ack();
        chk_reg("pend_after_ack1", PEND_OFS, 32'h20);
        bus_write(BASE + 32'h8, 32'h0);
        wait_intr("intr_second", 10);
        chk("id_5_second", 32'(bus.active_id), 32'd5);
        pulse_ack();
        bus_write(BASE + 32'h8, 32'h0);
        chk_reg("pend_pair_done", PEND_OFS, 32'h0);

        // withdraw by disabling while requested, then re-enable
        irq_src[3] = 1'b1;
        tick(3);
        irq_src = '0;
        wait_intr("intr_src3", 10);
        chk("id_3", 32'(bus.active_id), 32'd3);
        bus_write(BASE + 32'h4, 32'h0);
        chk("intr_withdrawn", 32'(bus.cpu_intr), 32'd0);
        chk("state_withdrawn", 32'(state_dbg), 32'(IDLE));
        chk_reg("pend_kept", PEND_OFS, 32'h08);
        tick(2);
        chk("intr_stays_off", 32'(bus.cpu_intr), 32'd0);
        bus_write(BASE + 32'h4, 32'h08);
        wait_intr("intr_reenable", 10);
        chk("id_3_again", 32'(bus.active_id), 32'd3);
        pulse_ack();
        bus_write(BASE + 32'h8, 32'h0);

        // edge and W1C on the same bit in the same cycle: set wins
        irq_src[4] = 1'b1;
        tick(2);
        bus_write(BASE + 32'h0, 32'h10);
        chk_reg("set_beats_w1c", PEND_OFS, 32'h10);
        irq_src = '0;
        bus_write(BASE + 32'h0, 32'h10);
        chk_reg("w1c_clears", PEND_OFS, 32'h0);
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
        chk_reg("ofs_c_reads0", 4'hC, 32'h0);
        chk_reg("en_unchanged_c", EN_OFS, 32'h08);

        // reset while in service
        bus_write(BASE + 32'h4, 32'h01);
        irq_src[0] = 1'b1;
        tick(3);
        irq_src = '0;
        wait_intr("intr_src0", 10);
        pulse_ack();
        chk("state_svc_pre_rst", 32'(state_dbg), 32'(SVC));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_state_idle", 32'(state_dbg), 32'(IDLE));
        chk("rst_intr_low", 32'(bus.cpu_intr), 32'd0);
        chk_reg("rst_en_zero", EN_OFS, 32'h0);
        chk_reg("rst_pend_zero", PEND_OFS, 32'h0);
        chk_reg("rst_stat_zero", STAT_OFS, 32'h0);

        // out-of-window accesses
        bus_write(BASE + 32'h4, 32'h03);
        bus_write(BASE + 32'h104, 32'h0);
        bus_write(BASE + 32'h100, 32'hFF);
        chk_addr("oow_read0", BASE + 32'h104, 32'h0);
        chk_reg("oow_en_kept", EN_OFS, 32'h03);
        chk_reg("oow_pend_kept", PEND_OFS, 32'h0);
        tick(3);
        chk("oow_no_intr", 32'(bus.cpu_intr), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
